// File: rtl/sdram_cmd_pkg.sv
// sdram_cmd_pkg: shared encodings for the SDRAM command scheduler.
// FSM states, recorded command codes and grant priority slots.
package sdram_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECOV,
    S_TRAIL
  } state_e;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_NOP   = 3'd1;
  localparam logic [2:0] CMD_REF   = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_WRITE = 3'd4;
  localparam logic [2:0] CMD_PRE   = 3'd5;
  localparam logic [2:0] CMD_LMR   = 3'd6;

  // Lower slot index wins the grant.
  localparam int PRIO_LMR  = 0;
  localparam int PRIO_PRE  = 1;
  localparam int PRIO_UREF = 2;
  localparam int PRIO_RD   = 3;
  localparam int PRIO_WR   = 4;
  localparam int PRIO_NREF = 5;
  localparam int PRIO_NOP  = 6;
  localparam int PRIO_N    = 7;

  function automatic logic has_trail(input logic [2:0] c);
    return (c == CMD_REF) || (c == CMD_READ) || (c == CMD_WRITE);
  endfunction

endpackage

// File: rtl/sdram_cmd_sched_if.sv
// sdram_cmd_sched_if: request/strobe bundle between the
// microprocessor side and the command scheduler.
interface sdram_cmd_sched_if #(
  parameter int CMD_DUR_W = 8,
  parameter int REF_DUR_W = 4,
  parameter int PEND_W    = 3
);
  logic                 nop;
  logic                 ref_req;
  logic                 refresh;
  logic                 reada;
  logic                 writea;
  logic                 precharge;
  logic                 load_mod;
  logic [CMD_DUR_W-1:0] cmd_dur;
  logic [REF_DUR_W-1:0] ref_dur;
  logic                 do_nop;
  logic                 do_reada;
  logic                 do_writea;
  logic                 do_refresh;
  logic                 do_precharge;
  logic                 do_load_mod;
  logic                 rw_flag;
  logic                 busy;
  logic [PEND_W-1:0]    ref_pending;
  logic                 ref_overflow;

  modport master (
    output nop, ref_req, refresh, reada, writea,
    output precharge, load_mod, cmd_dur, ref_dur,
    input  do_nop, do_reada, do_writea, do_refresh,
    input  do_precharge, do_load_mod, rw_flag, busy,
    input  ref_pending, ref_overflow
  );

  modport slave (
    input  nop, ref_req, refresh, reada, writea,
    input  precharge, load_mod, cmd_dur, ref_dur,
    output do_nop, do_reada, do_writea, do_refresh,
    output do_precharge, do_load_mod, rw_flag, busy,
    output ref_pending, ref_overflow
  );

endinterface

// File: rtl/sdram_down_timer.sv
// sdram_down_timer: loadable down-counter that parks at zero;
// last_o flags the final counted cycle.
module sdram_down_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/sdram_cmd_sched.sv
// sdram_cmd_sched: priority grant of level requests into one-cycle
// do_* strobes, with recovery/trail windows and a refresh queue.
module sdram_cmd_sched
  import sdram_cmd_pkg::*;
#(
  parameter int CMD_DUR_W  = 8,
  parameter int REF_DUR_W  = 4,
  parameter int PEND_W     = 3,
  parameter int REF_URGENT = 4
) (
  input  logic             clk0,
  input  logic             reset,
  sdram_cmd_sched_if.slave bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_URG = PEND_W'(REF_URGENT);

  state_e               state_q, state_d;
  logic [2:0]           str_q, last_q, last_d, grant;
  logic                 rw_q, rw_d;
  logic                 ovf_q, ovf_d;
  logic                 ref_req_q;
  logic [PEND_W-1:0]    pend_q, pend_d;
  logic [PRIO_N-1:0]    req;
  logic                 urgent, rise, dec;
  logic                 rec_load, trl_load;
  logic                 rec_last, trl_last;
  logic [CMD_DUR_W-1:0] rec_val;

  assign urgent  = bus.refresh || (pend_q >= PEND_URG);
  assign rise    = bus.ref_req && !ref_req_q;
  assign rec_val = (bus.cmd_dur == '0) ? CMD_DUR_W'(1) : bus.cmd_dur;

  always_comb begin
    req            = '0;
    req[PRIO_LMR]  = bus.load_mod;
    req[PRIO_PRE]  = bus.precharge;
    req[PRIO_UREF] = urgent;
    req[PRIO_RD]   = bus.reada;
    req[PRIO_WR]   = bus.writea;
    req[PRIO_NREF] = (pend_q != '0) && !urgent;
    // Back-to-back nops are suppressed.
    req[PRIO_NOP]  = bus.nop && (str_q != CMD_NOP);
    grant          = CMD_NONE;
    if (state_q == S_IDLE) begin
      priority case (1'b1)
        req[PRIO_LMR]:  grant = CMD_LMR;
        req[PRIO_PRE]:  grant = CMD_PRE;
        req[PRIO_UREF]: grant = CMD_REF;
        req[PRIO_RD]:   grant = CMD_READ;
        req[PRIO_WR]:   grant = CMD_WRITE;
        req[PRIO_NREF]: grant = CMD_REF;
        req[PRIO_NOP]:  grant = CMD_NOP;
        default:        grant = CMD_NONE;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    rw_d     = rw_q;
    rec_load = 1'b0;
    trl_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant != CMD_NONE && grant != CMD_NOP) begin
          state_d  = S_RECOV;
          rec_load = 1'b1;
          last_d   = grant;
          rw_d     = (grant == CMD_READ);
        end
      end
      S_RECOV: begin
        if (rec_last) begin
          if (has_trail(last_q) && bus.ref_dur != '0) begin
            state_d  = S_TRAIL;
            trl_load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_TRAIL: begin
        if (trl_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dec    = (grant == CMD_REF) && (pend_q != '0);
    pend_d = pend_q;
    ovf_d  = ovf_q || (rise && pend_q == PEND_MAX);
    if (rise && !dec && pend_q != PEND_MAX) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (dec && !rise) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      state_q   <= S_IDLE;
      str_q     <= CMD_NONE;
      last_q    <= CMD_NONE;
      rw_q      <= 1'b0;
      ovf_q     <= 1'b0;
      pend_q    <= '0;
      ref_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      str_q     <= grant;
      last_q    <= last_d;
      rw_q      <= rw_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
      ref_req_q <= bus.ref_req;
    end
  end

  sdram_down_timer #(.W(CMD_DUR_W)) u_rec (
    .clk_i  (clk0),
    .rst_i  (reset),
    .load_i (rec_load),
    .val_i  (rec_val),
    .last_o (rec_last)
  );

  sdram_down_timer #(.W(REF_DUR_W)) u_trl (
    .clk_i  (clk0),
    .rst_i  (reset),
    .load_i (trl_load),
    .val_i  (bus.ref_dur),
    .last_o (trl_last)
  );

  assign bus.do_nop       = (str_q == CMD_NOP);
  assign bus.do_refresh   = (str_q == CMD_REF);
  assign bus.do_reada     = (str_q == CMD_READ);
  assign bus.do_writea    = (str_q == CMD_WRITE);
  assign bus.do_precharge = (str_q == CMD_PRE);
  assign bus.do_load_mod  = (str_q == CMD_LMR);
  assign bus.rw_flag      = rw_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.ref_pending  = pend_q;
  assign bus.ref_overflow = ovf_q;

endmodule
